// File: rtl/reg_initiator_if.sv
// Command, response and register-file request signals shared by the bus initiator
// and whatever drives it (CPU/config side) and answers it (register file side).
interface reg_initiator_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int ERR_W  = 8
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_wr;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wr_data;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rd_data;
    logic [ERR_W-1:0]  rsp_err;
    logic              rsp_timeout;

    logic              o_req;
    logic              o_wr;
    logic [ADDR_W-1:0] o_addr;
    logic [DATA_W-1:0] o_wr_data;
    logic [DATA_W-1:0] i_rd_data;
    logic              i_ack;
    logic              i_credit;
    logic [ERR_W-1:0]  i_err;

    modport master (
        input  cmd_valid, cmd_wr, cmd_addr, cmd_wr_data, rsp_ready,
        input  i_rd_data, i_ack, i_credit, i_err,
        output cmd_ready, rsp_valid, rsp_rd_data, rsp_err, rsp_timeout,
        output o_req, o_wr, o_addr, o_wr_data
    );

    modport slave (
        output cmd_valid, cmd_wr, cmd_addr, cmd_wr_data, rsp_ready,
        output i_rd_data, i_ack, i_credit, i_err,
        input  cmd_ready, rsp_valid, rsp_rd_data, rsp_err, rsp_timeout,
        input  o_req, o_wr, o_addr, o_wr_data
    );
endinterface

// File: rtl/reg_initiator.sv
// Credit-gated, single-outstanding register-file initiator with ack timeout.
// Every output is a flop; the _d values are computed from the current state.
module reg_initiator #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int ERR_W   = 8,
    parameter int CREDITS = 4,
    parameter int TIMEOUT = 16,
    localparam int CW     = $clog2(CREDITS + 1)
) (
    input  logic          clk,
    input  logic          rst,
    reg_initiator_if.master bus,
    output logic [CW-1:0] credits,
    output logic          stray_ack
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    localparam logic [7:0]    TMO_LAST  = 8'(TIMEOUT - 1);
    localparam logic [CW-1:0] CRED_MAX  = CW'(CREDITS);

    state_t            state_q, state_d;
    logic [7:0]        timer_q, timer_d, timer_inc;
    logic [CW-1:0]     credits_q, credits_d;
    logic              cmd_ready_q, cmd_ready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rd_data_q, rsp_rd_data_d;
    logic [ERR_W-1:0]  rsp_err_q, rsp_err_d;
    logic              rsp_timeout_q, rsp_timeout_d;
    logic              o_req_q, o_req_d;
    logic              o_wr_q, o_wr_d;
    logic [ADDR_W-1:0] o_addr_q, o_addr_d;
    logic [DATA_W-1:0] o_wr_data_q, o_wr_data_d;
    logic              stray_ack_q, stray_ack_d;
    logic              accept;

    assign accept    = (state_q == IDLE) && bus.cmd_valid && cmd_ready_q;
    assign timer_inc = timer_q + 8'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            timer_q       <= '0;
            credits_q     <= CRED_MAX;
            cmd_ready_q   <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_rd_data_q <= '0;
            rsp_err_q     <= '0;
            rsp_timeout_q <= 1'b0;
            o_req_q       <= 1'b0;
            o_wr_q        <= 1'b0;
            o_addr_q      <= '0;
            o_wr_data_q   <= '0;
            stray_ack_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            credits_q     <= credits_d;
            cmd_ready_q   <= cmd_ready_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rd_data_q <= rsp_rd_data_d;
            rsp_err_q     <= rsp_err_d;
            rsp_timeout_q <= rsp_timeout_d;
            o_req_q       <= o_req_d;
            o_wr_q        <= o_wr_d;
            o_addr_q      <= o_addr_d;
            o_wr_data_q   <= o_wr_data_d;
            stray_ack_q   <= stray_ack_d;
        end
    end

    // An ack on the final timeout cycle still counts as a normal completion.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (accept) state_d = ISSUE;
            ISSUE: state_d = bus.i_ack ? RESP : WAIT;
            WAIT:  if (bus.i_ack || timer_inc == TMO_LAST) state_d = RESP;
            RESP:  if (bus.rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        timer_d       = timer_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_rd_data_d = rsp_rd_data_q;
        rsp_err_d     = rsp_err_q;
        rsp_timeout_d = rsp_timeout_q;
        o_req_d       = 1'b0;
        o_wr_d        = o_wr_q;
        o_addr_d      = o_addr_q;
        o_wr_data_d   = o_wr_data_q;
        stray_ack_d   = bus.i_ack && (state_q == IDLE || state_q == RESP);

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    o_req_d     = 1'b1;
                    o_wr_d      = bus.cmd_wr;
                    o_addr_d    = bus.cmd_addr;
                    o_wr_data_d = bus.cmd_wr_data;
                end
            end
            ISSUE, WAIT: begin
                timer_d = (state_q == ISSUE) ? 8'd0 : timer_inc;
                if (bus.i_ack) begin
                    rsp_valid_d   = 1'b1;
                    rsp_rd_data_d = o_wr_q ? '0 : bus.i_rd_data;
                    rsp_err_d     = bus.i_err;
                    rsp_timeout_d = 1'b0;
                end else if (state_q == WAIT && timer_inc == TMO_LAST) begin
                    rsp_valid_d   = 1'b1;
                    rsp_rd_data_d = '0;
                    rsp_err_d     = '0;
                    rsp_timeout_d = 1'b1;
                end
            end
            RESP: if (bus.rsp_ready) rsp_valid_d = 1'b0;
            default: ;
        endcase

        // Returns beyond the grant are dropped; issue plus return nets to zero.
        credits_d = credits_q;
        if (accept && !bus.i_credit)
            credits_d = credits_q - CW'(1);
        else if (!accept && bus.i_credit && credits_q != CRED_MAX)
            credits_d = credits_q + CW'(1);

        cmd_ready_d = (state_d == IDLE) && (credits_d != '0);
    end

    assign bus.cmd_ready   = cmd_ready_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_rd_data = rsp_rd_data_q;
    assign bus.rsp_err     = rsp_err_q;
    assign bus.rsp_timeout = rsp_timeout_q;
    assign bus.o_req       = o_req_q;
    assign bus.o_wr        = o_wr_q;
    assign bus.o_addr      = o_addr_q;
    assign bus.o_wr_data   = o_wr_data_q;
    assign credits         = credits_q;
    assign stray_ack       = stray_ack_q;
endmodule

// File: tb/tb_reg_initiator.sv
// Directed bench for reg_initiator: expected responses are queued at issue time
// and checked by an independent monitor on each response handshake.
module tb_reg_initiator;
    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int ERR_W   = 8;
    localparam int CREDITS = 4;
    localparam int TIMEOUT = 16;
    localparam int CW      = $clog2(CREDITS + 1);

    typedef struct packed {
        logic [DATA_W-1:0] rd;
        logic [ERR_W-1:0]  err;
        logic              tmo;
    } rsp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [CW-1:0] credits;
    logic          stray_ack;

    rsp_t exp_q[$];
    int   num_checks = 0;
    int   num_fail   = 0;

    reg_initiator_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ERR_W(ERR_W)) bus ();

    reg_initiator #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ERR_W(ERR_W),
        .CREDITS(CREDITS), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus),
        .credits(credits),
        .stray_ack(stray_ack)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        num_checks++;
        if (act !== exp) begin
            num_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic at_sample();
        @(negedge clk);
    endtask

    task automatic expect_rsp(input logic [DATA_W-1:0] rd, input logic [ERR_W-1:0] err, input logic tmo);
        rsp_t e;
        e.rd  = rd;
        e.err = err;
        e.tmo = tmo;
        exp_q.push_back(e);
    endtask

    // Returns at the start of the ISSUE cycle (just after the accepting edge).
    task automatic send_cmd(input logic wr, input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data);
        logic ok;
        ok = 1'b0;
        bus.cmd_valid   = 1'b1;
        bus.cmd_wr      = wr;
        bus.cmd_addr    = addr;
        bus.cmd_wr_data = data;
        for (int i = 0; i < 50; i++) begin
            at_sample();
            if (bus.cmd_ready) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        tick();
        bus.cmd_valid = 1'b0;
        check("cmd_accepted", ok, 1);
    endtask

    task automatic ack_after(input int d, input logic [DATA_W-1:0] rd, input logic [ERR_W-1:0] err);
        repeat (d) tick();
        bus.i_ack     = 1'b1;
        bus.i_rd_data = rd;
        bus.i_err     = err;
        tick();
        bus.i_ack = 1'b0;
    endtask

    task automatic credit_pulses(input int n);
        bus.i_credit = 1'b1;
        repeat (n) tick();
        bus.i_credit = 1'b0;
    endtask

    task automatic check_reset_outputs();
        check("rst_cmd_ready", bus.cmd_ready, 0);
        check("rst_rsp_valid", bus.rsp_valid, 0);
        check("rst_rsp_rd_data", bus.rsp_rd_data, 0);
        check("rst_rsp_err", bus.rsp_err, 0);
        check("rst_rsp_timeout", bus.rsp_timeout, 0);
        check("rst_o_req", bus.o_req, 0);
        check("rst_o_wr", bus.o_wr, 0);
        check("rst_o_addr", bus.o_addr, 0);
        check("rst_o_wr_data", bus.o_wr_data, 0);
        check("rst_stray_ack", stray_ack, 0);
        check("rst_credits", credits, CREDITS);
    endtask

    // Response monitor
    initial begin
        rsp_t e;
        forever begin
            @(negedge clk);
            if (bus.rsp_valid === 1'b1 && bus.rsp_ready === 1'b1) begin
                check("rsp_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("rsp_rd_data", bus.rsp_rd_data, e.rd);
                    check("rsp_err", bus.rsp_err, e.err);
                    check("rsp_timeout", bus.rsp_timeout, e.tmo);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst             = 1'b1;
        bus.cmd_valid   = 1'b0;
        bus.cmd_wr      = 1'b0;
        bus.cmd_addr    = '0;
        bus.cmd_wr_data = '0;
        bus.rsp_ready   = 1'b1;
        bus.i_rd_data   = '0;
        bus.i_ack       = 1'b0;
        bus.i_credit    = 1'b0;
        bus.i_err       = '0;

        repeat (2) tick();
        at_sample();
        check_reset_outputs();
        tick();
        rst = 1'b0;
        tick();
        at_sample();
        check("idle_cmd_ready", bus.cmd_ready, 1);

        $display("[TB] write with ack one cycle after req");
        tick();
        expect_rsp(32'h0, 8'h00, 1'b0);
        send_cmd(1'b1, 32'h4, 32'hA5A5_0001);
        at_sample();
        check("wr_o_req", bus.o_req, 1);
        check("wr_o_wr", bus.o_wr, 1);
        check("wr_o_addr", bus.o_addr, 32'h4);
        check("wr_o_wr_data", bus.o_wr_data, 32'hA5A5_0001);
        check("wr_credits", credits, 3);
        check("wr_cmd_ready_busy", bus.cmd_ready, 0);
        ack_after(1, 32'h1234_5678, 8'h00);
        at_sample();
        check("wr_rsp_valid", bus.rsp_valid, 1);
        check("wr_o_req_low", bus.o_req, 0);
        tick();
        at_sample();
        check("wr_rsp_done", bus.rsp_valid, 0);
        check("wr_back_idle", bus.cmd_ready, 1);
        credit_pulses(1);
        at_sample();
        check("wr_credit_back", credits, 4);

        $display("[TB] read with ack two cycles after req");
        tick();
        expect_rsp(32'hDEAD_BEEF, 8'h03, 1'b0);
        send_cmd(1'b0, 32'h8, 32'hFFFF_0000);
        at_sample();
        check("rd_o_wr", bus.o_wr, 0);
        check("rd_o_addr", bus.o_addr, 32'h8);
        ack_after(2, 32'hDEAD_BEEF, 8'h03);
        at_sample();
        check("rd_rsp_valid", bus.rsp_valid, 1);
        tick();
        credit_pulses(1);
        at_sample();
        check("rd_credit_back", credits, 4);

        $display("[TB] credit exhaustion");
        for (int i = 0; i < 4; i++) begin
            tick();
            expect_rsp(32'h100 + i, 8'h00, 1'b0);
            send_cmd(1'b0, 32'h10 + i, 32'h0);
            ack_after(1, 32'h100 + i, 8'h00);
            tick();
        end
        at_sample();
        check("cred_zero", credits, 0);
        check("cred_zero_not_ready", bus.cmd_ready, 0);
        tick();
        bus.cmd_valid = 1'b1;
        bus.cmd_wr    = 1'b0;
        bus.cmd_addr  = 32'h50;
        repeat (3) begin
            at_sample();
            check("cred_held_ready", bus.cmd_ready, 0);
            check("cred_held_no_req", bus.o_req, 0);
            tick();
        end
        expect_rsp(32'h55, 8'h01, 1'b0);
        bus.i_credit = 1'b1;
        tick();
        at_sample();
        check("cred_return_ready", bus.cmd_ready, 1);
        check("cred_return_count", credits, 1);
        tick();
        bus.cmd_valid = 1'b0;
        bus.i_credit  = 1'b0;
        at_sample();
        check("cred_5th_req", bus.o_req, 1);
        check("cred_5th_addr", bus.o_addr, 32'h50);
        check("cred_simultaneous", credits, 1);
        ack_after(0, 32'h55, 8'h01);
        at_sample();
        check("cred_5th_rsp", bus.rsp_valid, 1);
        tick();
        credit_pulses(3);
        at_sample();
        check("cred_refilled", credits, 4);

        $display("[TB] timeout and late ack");
        tick();
        expect_rsp(32'h0, 8'h00, 1'b1);
        bus.i_rd_data = 32'hFFFF_FFFF;
        bus.i_err     = 8'hFF;
        send_cmd(1'b0, 32'h20, 32'h0);
        for (int i = 1; i <= TIMEOUT; i++) begin
            tick();
            if (i == TIMEOUT - 1) begin
                at_sample();
                check("tmo_not_yet", bus.rsp_valid, 0);
            end
        end
        at_sample();
        check("tmo_rsp_valid", bus.rsp_valid, 1);
        check("tmo_flag", bus.rsp_timeout, 1);
        tick();
        bus.i_ack = 1'b1;
        tick();
        bus.i_ack = 1'b0;
        at_sample();
        check("late_stray_ack", stray_ack, 1);
        check("late_no_rsp", bus.rsp_valid, 0);
        tick();
        at_sample();
        check("late_stray_clear", stray_ack, 0);
        check("late_no_rsp2", bus.rsp_valid, 0);
        tick();
        credit_pulses(1);
        at_sample();
        check("tmo_credit_back", credits, 4);

        $display("[TB] response backpressure and credit saturation");
        tick();
        bus.rsp_ready = 1'b0;
        expect_rsp(32'h0, 8'h07, 1'b0);
        send_cmd(1'b1, 32'h30, 32'hCAFE_F00D);
        ack_after(1, 32'h1111_2222, 8'h07);
        bus.cmd_valid = 1'b1;
        bus.cmd_addr  = 32'h34;
        repeat (5) begin
            at_sample();
            check("hold_rsp_valid", bus.rsp_valid, 1);
            check("hold_rsp_err", bus.rsp_err, 8'h07);
            check("hold_rsp_rd_data", bus.rsp_rd_data, 0);
            check("hold_no_req", bus.o_req, 0);
            tick();
        end
        bus.cmd_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        at_sample();
        tick();
        at_sample();
        check("hold_released_ready", bus.cmd_ready, 1);
        credit_pulses(7);
        at_sample();
        check("cred_saturated", credits, 4);

        $display("[TB] reset during WAIT");
        tick();
        send_cmd(1'b0, 32'h40, 32'h0);
        tick();
        tick();
        at_sample();
        check("wait_credits", credits, 3);
        tick();
        rst = 1'b1;
        tick();
        at_sample();
        check_reset_outputs();
        rst = 1'b0;
        tick();
        at_sample();
        check("post_rst_ready", bus.cmd_ready, 1);
        tick();
        expect_rsp(32'h0, 8'h00, 1'b0);
        send_cmd(1'b1, 32'h44, 32'h0BAD_CAFE);
        at_sample();
        check("post_rst_req", bus.o_req, 1);
        check("post_rst_addr", bus.o_addr, 32'h44);
        ack_after(1, 32'h0, 8'h00);
        at_sample();
        check("post_rst_rsp", bus.rsp_valid, 1);
        tick();

        repeat (3) tick();
        check("rsp_queue_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fail);
        $finish;
    end
endmodule
